i2c_reg_slave: RTL

I2C target (responder) with 16-bit register addressing and an internal byte register file. It is the far end of the I2C master command path: it answers the same transaction format the master issues (device address, 16-bit register address high then low, then data). It serves as an on-board peripheral model and as a loopback target for master bring-up. It samples SCL and SDA on the system clock and never drives SCL.

---
 rtl/i2c_reg_slave.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_slave.sv
// ---------------------------------------------------------------------------
// i2c_reg_slave
// I2C target with a 16-bit register pointer and an internal byte register
// file. Transaction format: device address + R/W, pointer high, pointer low,
// then data bytes (write), or device address + R and data bytes read from the
// current pointer (read, usually after a repeated start). SCL and SDA are
// oversampled on Clk; SCL is never driven, SDA is driven only low.
//
// Ports
//   Clk        system clock
//   Rst_n      asynchronous active-low reset
//   i2c_sclk   I2C clock from the master
//   i2c_sdat   I2C data, open drain (0 or Z)
//   busy       addressed and inside a transfer
//   wr_pulse   one-cycle strobe per byte written into the register file
//   wr_addr    full 16-bit pointer of that byte
//   wr_data    byte written
//   rd_pulse   one-cycle strobe when a byte is loaded for transmission
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | bus idle or not addressed, wait for START
// S_DEV   | receive device address + R/W, ACK on match
// S_AH    | receive pointer[15:8], ACK
// S_AL    | receive pointer[7:0], ACK
// S_WDATA | receive data byte, write register, ACK, pointer+1
// S_RDATA | transmit register byte, sample master ACK/NACK
// S_WAITP | master NACKed a read, SDA released until STOP or START
// ---------------------------------------------------------------------------
module i2c_reg_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h3C,
    parameter int         DEPTH    = 256,
    parameter int         FILT     = 3
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        i2c_sclk,
    inout  wire         i2c_sdat,
    output logic        busy,
    output logic        wr_pulse,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_pulse
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(FILT + 1);
    localparam logic [CW-1:0] FILT_LD = CW'(FILT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DEV, S_AH, S_AL, S_WDATA, S_RDATA, S_WAITP
    } state_t;

    // ---------------- input path: sync + glitch filter ----------------
    // bit 0 = SCL, bit 1 = SDA
    logic [1:0]    pin_raw, pin_s1, pin_s2, line_f, line_d;
    logic [CW-1:0] flt_cnt [2];

    assign pin_raw = {i2c_sdat, i2c_sclk};

    // Filter is a down-counter reloaded while the synchronised pin agrees
    // with the filtered value; FILT consecutive differing samples flip it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pin_s1 <= 2'b11;
            pin_s2 <= 2'b11;
            line_f <= 2'b11;
            line_d <= 2'b11;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= FILT_LD;
        end else begin
            pin_s1 <= pin_raw;
            pin_s2 <= pin_s1;
            line_d <= line_f;
            for (int i = 0; i < 2; i++) begin
                if (pin_s2[i] == line_f[i]) begin
                    flt_cnt[i] <= FILT_LD;
                end else if (flt_cnt[i] == '0) begin
                    line_f[i]  <= pin_s2[i];
                    flt_cnt[i] <= FILT_LD;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] - 1'b1;
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det, sda_in;
    assign scl_rise  =  line_f[0] & ~line_d[0];
    assign scl_fall  = ~line_f[0] &  line_d[0];
    assign start_det =  line_f[0] & line_d[0] & ~line_f[1] &  line_d[1];
    assign stop_det  =  line_f[0] & line_d[0] &  line_f[1] & ~line_d[1];
    assign sda_in    =  line_f[1];

    // ---------------- state and datapath registers ----------------
    state_t      state, state_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic        ack_ph, ack_ph_nxt;     // inside the 9th (ACK) clock
    logic        byte_end, byte_end_nxt; // 8th bit seen, ACK slot on next fall
    logic        m_ack, m_ack_nxt;
    logic        rw, rw_nxt;
    logic        sda_oe, sda_oe_nxt;
    logic        busy_nxt;
    logic [15:0] ptr, ptr_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        wr_pulse_nxt, rd_pulse_nxt;
    logic [15:0] wr_addr_nxt;
    logic [7:0]  wr_data_nxt;
    logic        reg_we;
    logic [7:0]  rx_byte, rd_byte;
    logic [7:0]  regs [DEPTH];

    assign rx_byte  = {shreg[6:0], sda_in};
    assign rd_byte  = regs[ptr[IW-1:0]];
    assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        ack_ph_nxt   = ack_ph;
        byte_end_nxt = byte_end;
        m_ack_nxt    = m_ack;
        rw_nxt       = rw;
        sda_oe_nxt   = sda_oe;
        busy_nxt     = busy;
        ptr_nxt      = ptr;
        shreg_nxt    = shreg;
        wr_pulse_nxt = 1'b0;
        wr_addr_nxt  = wr_addr;
        wr_data_nxt  = wr_data;
        rd_pulse_nxt = 1'b0;
        reg_we       = 1'b0;

        if (start_det) begin
            state_nxt    = S_DEV;
            bit_cnt_nxt  = 3'd0;
            ack_ph_nxt   = 1'b0;
            byte_end_nxt = 1'b0;
            sda_oe_nxt   = 1'b0;
        end else if (stop_det) begin
            // STOP in IDLE leaves everything as it already is.
            state_nxt    = S_IDLE;
            bit_cnt_nxt  = 3'd0;
            ack_ph_nxt   = 1'b0;
            byte_end_nxt = 1'b0;
            sda_oe_nxt   = 1'b0;
            busy_nxt     = 1'b0;
        end else begin
            case (state)
                S_DEV, S_AH, S_AL, S_WDATA: begin
                    if (scl_rise && !ack_ph) begin
                        shreg_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_end_nxt = 1'b1;
                            case (state)
                                S_DEV: begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        busy_nxt = 1'b1;
                                        rw_nxt   = rx_byte[0];
                                    end else begin
                                        state_nxt    = S_IDLE;
                                        busy_nxt     = 1'b0;
                                        byte_end_nxt = 1'b0;
                                    end
                                end
                                S_AH: ptr_nxt[15:8] = rx_byte;
                                S_AL: ptr_nxt[7:0]  = rx_byte;
                                default: begin
                                    reg_we       = 1'b1;
                                    wr_pulse_nxt = 1'b1;
                                    wr_addr_nxt  = ptr;
                                    wr_data_nxt  = rx_byte;
                                    ptr_nxt      = ptr + 16'd1;
                                end
                            endcase
                        end
                    end else if (scl_fall) begin
                        if (ack_ph) begin
                            ack_ph_nxt  = 1'b0;
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = 3'd0;
                            case (state)
                                S_DEV: begin
                                    if (rw) begin
                                        // First read bit goes out on the same
                                        // fall that ends the address ACK.
                                        state_nxt    = S_RDATA;
                                        shreg_nxt    = rd_byte;
                                        rd_pulse_nxt = 1'b1;
                                        sda_oe_nxt   = ~rd_byte[7];
                                    end else begin
                                        state_nxt = S_AH;
                                    end
                                end
                                S_AH:    state_nxt = S_AL;
                                S_AL:    state_nxt = S_WDATA;
                                default: state_nxt = S_WDATA;
                            endcase
                        end else if (byte_end) begin
                            byte_end_nxt = 1'b0;
                            ack_ph_nxt   = 1'b1;
                            sda_oe_nxt   = 1'b1;
                        end
                    end
                end

                S_RDATA: begin
                    if (scl_rise) begin
                        if (ack_ph) begin
                            m_ack_nxt = ~sda_in;
                            if (!sda_in) ptr_nxt = ptr + 16'd1;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_end_nxt = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (ack_ph) begin
                            ack_ph_nxt = 1'b0;
                            if (m_ack) begin
                                shreg_nxt    = rd_byte;
                                rd_pulse_nxt = 1'b1;
                                sda_oe_nxt   = ~rd_byte[7];
                                bit_cnt_nxt  = 3'd0;
                            end else begin
                                state_nxt  = S_WAITP;
                                sda_oe_nxt = 1'b0;
                            end
                        end else if (byte_end) begin
                            byte_end_nxt = 1'b0;
                            ack_ph_nxt   = 1'b1;
                            sda_oe_nxt   = 1'b0;
                        end else begin
                            shreg_nxt  = {shreg[6:0], 1'b0};
                            sda_oe_nxt = ~shreg[6];
                        end
                    end
                end

                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= S_IDLE;
            bit_cnt  <= 3'd0;
            ack_ph   <= 1'b0;
            byte_end <= 1'b0;
            m_ack    <= 1'b0;
            rw       <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            ptr      <= 16'd0;
            shreg    <= 8'd0;
            wr_pulse <= 1'b0;
            wr_addr  <= 16'd0;
            wr_data  <= 8'd0;
            rd_pulse <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            ack_ph   <= ack_ph_nxt;
            byte_end <= byte_end_nxt;
            m_ack    <= m_ack_nxt;
            rw       <= rw_nxt;
            sda_oe   <= sda_oe_nxt;
            busy     <= busy_nxt;
            ptr      <= ptr_nxt;
            shreg    <= shreg_nxt;
            wr_pulse <= wr_pulse_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_data  <= wr_data_nxt;
            rd_pulse <= rd_pulse_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
        end else if (reg_we) begin
            regs[ptr[IW-1:0]] <= rx_byte;
        end
    end

endmodule
